// File: rtl/radix4_booth_wallace_24.sv
// +--------------------------------------------------------------------------+
// | radix4_booth_wallace_24: 24x24 signed/unsigned radix-4 Booth multiplier   |
// | Wallace-tree CSA reduction, final CPA, one output register. Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module radix4_booth_wallace_24 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        signedFlag,
   input  logic [23:0] multiplicand,
   input  logic [23:0] multiplier,
   output logic [47:0] out
);

   localparam int c_NUM_PP = 13;

   logic [25:0] x_ext;
   logic [26:0] y_pad;
   logic [47:0] rows0 [14];
   logic [47:0] rows1 [10];
   logic [47:0] rows2 [7];
   logic [47:0] rows3 [5];
   logic [47:0] rows4 [4];
   logic [47:0] rows5 [3];
   logic [47:0] rows6 [2];
   logic [47:0] product_d;
   logic [47:0] product_q;

   function automatic logic [47:0] csa_s(input logic [47:0] a, input logic [47:0] b,
                                         input logic [47:0] c);
      return a ^ b ^ c;
   endfunction

   function automatic logic [47:0] csa_c(input logic [47:0] a, input logic [47:0] b,
                                         input logic [47:0] c);
      return ((a & b) | (a & c) | (b & c)) << 1;
   endfunction

   // Booth recoding: 13 sign-extended partial products plus one row holding
   // the +1 negation corrections (they sit on disjoint even bit positions).
   always_comb begin
      logic [2:0]  trip;
      logic        one;
      logic        two;
      logic        neg;
      logic [26:0] mag;
      logic [26:0] sel;
      logic [47:0] corr;
      x_ext = signedFlag ? {{2{multiplicand[23]}}, multiplicand} : {2'b00, multiplicand};
      y_pad = {(signedFlag ? {2{multiplier[23]}} : 2'b00), multiplier, 1'b0};
      corr  = '0;
      trip  = '0;
      one   = 1'b0;
      two   = 1'b0;
      neg   = 1'b0;
      mag   = '0;
      sel   = '0;
      for (int i = 0; i < c_NUM_PP; i++) begin
         trip = y_pad[2*i +: 3];
         one  = trip[1] ^ trip[0];
         two  = (trip == 3'b100) || (trip == 3'b011);
         neg  = trip[2] & ~(trip[1] & trip[0]);
         if (one)
            mag = {x_ext[25], x_ext};
         else if (two)
            mag = {x_ext, 1'b0};
         else
            mag = '0;
         sel = neg ? ~mag : mag;
         rows0[i] = {{21{sel[26]}}, sel} << (2*i);
         corr[2*i] = neg;
      end
      rows0[13] = corr;
   end

   // Wallace layers: 14 -> 10 -> 7 -> 5 -> 4 -> 3 -> 2 rows.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         rows1[2*k]   = csa_s(rows0[3*k], rows0[3*k+1], rows0[3*k+2]);
         rows1[2*k+1] = csa_c(rows0[3*k], rows0[3*k+1], rows0[3*k+2]);
      end
      rows1[8] = rows0[12];
      rows1[9] = rows0[13];

      for (int k = 0; k < 3; k++) begin
         rows2[2*k]   = csa_s(rows1[3*k], rows1[3*k+1], rows1[3*k+2]);
         rows2[2*k+1] = csa_c(rows1[3*k], rows1[3*k+1], rows1[3*k+2]);
      end
      rows2[6] = rows1[9];

      for (int k = 0; k < 2; k++) begin
         rows3[2*k]   = csa_s(rows2[3*k], rows2[3*k+1], rows2[3*k+2]);
         rows3[2*k+1] = csa_c(rows2[3*k], rows2[3*k+1], rows2[3*k+2]);
      end
      rows3[4] = rows2[6];

      rows4[0] = csa_s(rows3[0], rows3[1], rows3[2]);
      rows4[1] = csa_c(rows3[0], rows3[1], rows3[2]);
      rows4[2] = rows3[3];
      rows4[3] = rows3[4];

      rows5[0] = csa_s(rows4[0], rows4[1], rows4[2]);
      rows5[1] = csa_c(rows4[0], rows4[1], rows4[2]);
      rows5[2] = rows4[3];

      rows6[0] = csa_s(rows5[0], rows5[1], rows5[2]);
      rows6[1] = csa_c(rows5[0], rows5[1], rows5[2]);

      product_d = rows6[0] + rows6[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         product_q <= '0;
      else
         product_q <= product_d;
   end

   assign out = product_q;

endmodule

`default_nettype wire

// File: tb/tb_radix4_booth_wallace_24.sv
// +--------------------------------------------------------------------------+
// | tb_radix4_booth_wallace_24: scoreboard bench for the 24x24 multiplier     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_radix4_booth_wallace_24;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        signed_flag = 1'b0;
   logic [23:0] x_in = '0;
   logic [23:0] y_in = '0;
   logic [47:0] prod;

   int checks = 0;
   int failures = 0;

   logic [47:0] exp_q [$];
   string       tag_q [$];
   logic [47:0] sb_exp;
   string       sb_tag;

   radix4_booth_wallace_24 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .signedFlag   (signed_flag),
      .multiplicand (x_in),
      .multiplier   (y_in),
      .out          (prod)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] golden(input logic sf, input logic [23:0] a,
                                          input logic [23:0] b);
      logic [47:0] ae;
      logic [47:0] be;
      ae = sf ? {{24{a[23]}}, a} : {24'h0, a};
      be = sf ? {{24{b[23]}}, b} : {24'h0, b};
      return ae * be;
   endfunction

   task automatic drive(input string tag, input logic sf, input logic [23:0] a,
                        input logic [23:0] b, input logic [47:0] e);
      @(negedge clk);
      signed_flag = sf;
      x_in = a;
      y_in = b;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Each pushed result is due one rising edge after its inputs were applied.
   always @(posedge clk) begin
      #1;
      if (rst_n && exp_q.size() > 0) begin
         sb_exp = exp_q.pop_front();
         sb_tag = tag_q.pop_front();
         chk(sb_tag, prod, sb_exp);
      end
   end

   initial begin
      logic [23:0] a;
      logic [23:0] b;
      logic        sf;

      rst_n = 1'b0;
      signed_flag = 1'b0;
      x_in = 24'hFFFFFF;
      y_in = 24'hFFFFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_hold", prod, 48'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_release", prod, 48'hFFFFFE000001);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async", prod, 48'h0);
      @(negedge clk);
      rst_n = 1'b1;

      drive("u_zero",   1'b0, 24'h000000, 24'hABCDEF, 48'h000000000000);
      drive("u_msb_x3", 1'b0, 24'h800000, 24'h000003, 48'h000001800000);
      drive("u_max_x1", 1'b0, 24'hFFFFFF, 24'h000001, 48'h000000FFFFFF);
      drive("u_maxmax", 1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
      drive("s_m1m1",   1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'h000000000001);
      drive("s_minmin", 1'b1, 24'h800000, 24'h800000, 48'h400000000000);
      drive("s_maxmin", 1'b1, 24'h7FFFFF, 24'h800000, 48'hC00000800000);
      drive("s_m1x5",   1'b1, 24'hFFFFFF, 24'h000005, 48'hFFFFFFFFFFFB);
      drive("b2b_u",    1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
      drive("b2b_s",    1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'h000000000001);
      drive("b2b_u2",   1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);

      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i <= 65; i++) begin
            for (int j = 0; j <= 65; j++) begin
               sf = (s != 0);
               a = (i == 65) ? 24'hFFFFFF : 24'(i * 32'h3FFFF);
               b = (j == 65) ? 24'hFFFFFF : 24'(j * 32'h3FFFF);
               drive("sweep", sf, a, b, golden(sf, a, b));
            end
         end
      end

      for (int n = 0; n < 20000; n++) begin
         sf = 1'($urandom_range(0, 1));
         a = 24'($urandom);
         b = 24'($urandom);
         drive("random", sf, a, b, golden(sf, a, b));
      end

      @(negedge clk);
      @(negedge clk);
      chk("drain", 48'(exp_q.size()), 48'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
